ptp_extts_sched: RTL and testbench
==================================

PTP_EXTTS_SCHED -- requirements
Module: ptp_extts_sched

Interface
REQ-001 SHALL provide parameter CH_COUNT, default 4, number of external-timestamp channels serviced (1..8).
REQ-002 SHALL provide parameter FIFO_DEPTH, default 8, event queue depth in entries (power of 2, 2..64).
REQ-003 SHALL provide port clk, input, 1, single clock for all logic; one clock, no other clock domains.
REQ-004 SHALL provide port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL provide port ch_ts, input, CH_COUNT*96, per-channel latched timestamp; channel i at bits [96*i+95:96*i].
REQ-006 SHALL provide port ch_locked, input, CH_COUNT, per-channel timestamp-valid level.
REQ-007 SHALL provide port ch_step, input, CH_COUNT, per-channel PTP-step level.
REQ-008 SHALL provide port cfg_enable, input, CH_COUNT, software channel enable.
REQ-009 SHALL provide port ch_enable, output, CH_COUNT, registered copy of cfg_enable, driven to the channels.
REQ-010 SHALL provide port ch_arm, output, CH_COUNT, one-cycle re-arm pulse per channel.
REQ-011 SHALL provide port evt_ts, output, 96, head-of-queue timestamp.
REQ-012 SHALL provide port evt_ch, output, 3, head-of-queue channel index.
REQ-013 SHALL provide port evt_valid, output, 1, queue non-empty.
REQ-014 SHALL provide port evt_ready, input, 1, consumer pop; a pop occurs when evt_valid and evt_ready are both high.
REQ-015 SHALL provide port fifo_count, output, 7, current queue occupancy.
REQ-016 SHALL provide port overflow, output, 1, sticky event-dropped flag.
REQ-017 SHALL provide port overflow_clr, input, 1, clears overflow.
REQ-018 SHALL provide port step_event, output, 1, one-cycle pulse on any channel step rising edge.

Function
REQ-019 SHALL register ch_locked and ch_step each cycle; a rising edge is current=1 and previous=0.
REQ-020 SHALL set pending[i] on a ch_locked[i] rising edge while ch_enable[i]=1; rising edges on disabled channels are ignored.
REQ-021 SHALL grant at most one pending channel per cycle using round-robin, starting the search at (last granted + 1) mod CH_COUNT; after reset, search starts at channel 0.
REQ-022 SHALL, on a grant, clear pending[i], write {i, ch_ts[i]} into the queue, and pulse ch_arm[i] for exactly one cycle in the following cycle.
REQ-023 SHALL give latency as follows: edge sampled in cycle N -> pending in N+1 -> grant in N+1 -> evt_valid and ch_arm in N+2 (empty queue).
REQ-024 SHALL accept a write when fifo_count<FIFO_DEPTH or a pop occurs in the same cycle; simultaneous write and pop leaves fifo_count unchanged.
REQ-025 SHALL, on a grant into a full queue with no pop, discard the entry, still pulse ch_arm[i], and set overflow.
REQ-026 SHALL present the queue first-word-fall-through, in strict FIFO order; evt_ts/evt_ch are stable while evt_valid=1 and no pop occurs.
REQ-027 SHALL, on a ch_step[i] rising edge, clear pending[i] and pulse step_event; if a step edge and a locked edge on the same channel coincide, the step wins and pending stays clear.
REQ-028 SHALL prioritize overflow_clr below a same-cycle overflow set; in that case overflow stays 1.
REQ-029 SHALL, when cfg_enable[i] falls, clear pending[i]; queued entries from channel i are retained.
REQ-030 SHALL wrap read/write pointers modulo FIFO_DEPTH without loss.

Reset
REQ-031 SHALL, on rst=1, clear pending, edge registers, pointers, fifo_count=0, evt_valid=0, overflow=0, step_event=0, ch_arm=0, ch_enable=0, and round-robin pointer to 0.
REQ-032 SHALL discard queued and in-flight grants on reset mid-operation; no ch_arm pulse is issued in the cycle after reset.

Configuration
REQ-033 SHALL support macro PTP_EXTTS_SCHED_STEP_FLUSH_EN: when defined, any ch_step rising edge also empties the queue (fifo_count=0 next cycle) and clears all pending bits, and a same-cycle grant is discarded without setting overflow; when undefined, only REQ-027 applies and queue contents are retained.

Verification
REQ-034 SHALL cover the following: with cfg_enable=4'hF, raise ch_locked[2] with ch_ts[2]=96'h1234 -> evt_valid at N+2 with evt_ch=2, evt_ts=96'h1234, and ch_arm=4'b0100 for one cycle.
REQ-035 SHALL cover the following: ch_locked[0..3] rising together, evt_ready=1 -> grants in order 0,1,2,3 on consecutive cycles and four entries delivered in that order.
REQ-036 SHALL cover the following: FIFO_DEPTH=8, evt_ready=0, and 9 events -> fifo_count=8, overflow=1, all 9 ch_arm pulses issued; overflow_clr -> overflow=0.
REQ-037 SHALL cover the following: queue full plus simultaneous pop and grant -> fifo_count stays 8, overflow stays 0, and the new entry appears last.
REQ-038 SHALL cover the following: 3 entries queued, then ch_step[1] rises -> step_event pulse; with the macro, fifo_count=0; without it, fifo_count=3.
REQ-039 SHALL cover the following: rst asserted with 5 entries queued and pending=4'hA -> next cycle fifo_count=0, evt_valid=0, ch_arm=0.

Source files
------------

// File: rtl/ptp_extts_sched.sv
// ptp_extts_sched: round-robin scheduler that queues external PTP timestamps.
// Optional macro PTP_EXTTS_SCHED_STEP_FLUSH_EN: a step edge also empties the queue.
module ptp_extts_sched #(
   parameter int CH_COUNT   = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CH_COUNT*96-1:0] ch_ts,
   input  logic [CH_COUNT-1:0]   ch_locked,
   input  logic [CH_COUNT-1:0]   ch_step,
   input  logic [CH_COUNT-1:0]   cfg_enable,
   output logic [CH_COUNT-1:0]   ch_enable,
   output logic [CH_COUNT-1:0]   ch_arm,
   output logic [95:0]           evt_ts,
   output logic [2:0]            evt_ch,
   output logic                  evt_valid,
   input  logic                  evt_ready,
   output logic [6:0]            fifo_count,
   output logic                  overflow,
   input  logic                  overflow_clr,
   output logic                  step_event
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [CH_COUNT-1:0] locked_q, locked_d;
   logic [CH_COUNT-1:0] step_q, step_d;
   logic [CH_COUNT-1:0] en_q, en_d;
   logic [CH_COUNT-1:0] pend_q, pend_d;
   logic [CH_COUNT-1:0] arm_q, arm_d;
   logic [AW-1:0]       wptr_q, wptr_d;
   logic [AW-1:0]       rptr_q, rptr_d;
   logic [6:0]          cnt_q, cnt_d;
   logic                ovf_q, ovf_d;
   logic                stp_q, stp_d;
   logic [2:0]          rr_q, rr_d;
   logic [98:0]         mem_q [FIFO_DEPTH];

   logic [CH_COUNT-1:0] lock_rise, step_rise, cfg_fall, gnt_oh;
   logic                gnt_vld;
   logic [2:0]          gnt_idx;
   logic [95:0]         wr_ts;
   logic                pop, full, flush, wr_en, ovf_set;

   function automatic int rot_idx(input int base, input int k);
      int j;
      j = base + k;
      if (j >= CH_COUNT) j = j - CH_COUNT;
      return j;
   endfunction

   // Round-robin pick of one pending channel, starting after the last grant
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      gnt_oh  = '0;
      wr_ts   = '0;
      for (int k = 0; k < CH_COUNT; k++) begin
         if (!gnt_vld && pend_q[rot_idx(int'(rr_q), k)]) begin
            gnt_vld = 1'b1;
            gnt_idx = 3'(rot_idx(int'(rr_q), k));
         end
      end
      for (int i = 0; i < CH_COUNT; i++) begin
         gnt_oh[i] = gnt_vld && (int'(gnt_idx) == i);
         if (gnt_oh[i]) wr_ts = ch_ts[96*i +: 96];
      end
   end

   // Edge detection, pending bookkeeping, queue pointers and flags
   always_comb begin
      locked_d  = ch_locked;
      step_d    = ch_step;
      en_d      = cfg_enable;
      lock_rise = ch_locked & ~locked_q;
      step_rise = ch_step & ~step_q;
      cfg_fall  = en_q & ~cfg_enable;
      stp_d     = |step_rise;
      arm_d     = gnt_oh;
      flush     = 1'b0;
`ifdef PTP_EXTTS_SCHED_STEP_FLUSH_EN
      flush     = |step_rise;
`endif
      pop       = (cnt_q != 7'd0) && evt_ready;
      full      = (cnt_q == 7'(FIFO_DEPTH));
      wr_en     = gnt_vld && !flush && (!full || pop);
      ovf_set   = gnt_vld && !flush && full && !pop;

      pend_d = (pend_q & ~gnt_oh) | (lock_rise & en_q);
      pend_d = pend_d & ~step_rise & ~cfg_fall;
      if (flush) pend_d = '0;

      rr_d = rr_q;
      if (gnt_vld) begin
         if (int'(gnt_idx) == CH_COUNT - 1) rr_d = '0;
         else rr_d = gnt_idx + 3'd1;
      end

      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (flush) begin
         rptr_d = wptr_q;
         cnt_d  = '0;
      end else begin
         if (wr_en) wptr_d = wptr_q + AW'(1);
         if (pop)   rptr_d = rptr_q + AW'(1);
         cnt_d = cnt_q + 7'(wr_en) - 7'(pop);
      end

      if (ovf_set) ovf_d = 1'b1;
      else if (overflow_clr) ovf_d = 1'b0;
      else ovf_d = ovf_q;
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         locked_q <= '0;
         step_q   <= '0;
         en_q     <= '0;
         pend_q   <= '0;
         arm_q    <= '0;
         wptr_q   <= '0;
         rptr_q   <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         stp_q    <= 1'b0;
         rr_q     <= '0;
      end else begin
         locked_q <= locked_d;
         step_q   <= step_d;
         en_q     <= en_d;
         pend_q   <= pend_d;
         arm_q    <= arm_d;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         stp_q    <= stp_d;
         rr_q     <= rr_d;
      end
   end

   // Queue storage; contents are don't-care while the count is zero
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wptr_q] <= {gnt_idx, wr_ts};
   end

   assign ch_enable  = en_q;
   assign ch_arm     = arm_q;
   assign evt_ts     = mem_q[rptr_q][95:0];
   assign evt_ch     = mem_q[rptr_q][98:96];
   assign evt_valid  = (cnt_q != 7'd0);
   assign fifo_count = cnt_q;
   assign overflow   = ovf_q;
   assign step_event = stp_q;

endmodule

// File: tb/tb_ptp_extts_sched.sv
// tb_ptp_extts_sched: scoreboard bench for the PTP external-timestamp scheduler.
// Expected queue entries are pushed on stimulus and checked on each pop.
module tb_ptp_extts_sched;

   localparam int CH    = 4;
   localparam int DEPTH = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [CH*96-1:0]  ch_ts;
   logic [CH-1:0]     ch_locked, ch_step, cfg_enable;
   logic [CH-1:0]     ch_enable, ch_arm;
   logic [95:0]       evt_ts;
   logic [2:0]        evt_ch;
   logic              evt_valid, evt_ready;
   logic [6:0]        fifo_count;
   logic              overflow, overflow_clr, step_event;

   logic [98:0]       sb[$];
   logic [98:0]       e;
   int                n_tests = 0;
   int                n_fail  = 0;
   int                arm_total = 0;
   int                arm_base;

   ptp_extts_sched #(.CH_COUNT(CH), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .ch_ts(ch_ts), .ch_locked(ch_locked),
      .ch_step(ch_step), .cfg_enable(cfg_enable), .ch_enable(ch_enable),
      .ch_arm(ch_arm), .evt_ts(evt_ts), .evt_ch(evt_ch),
      .evt_valid(evt_valid), .evt_ready(evt_ready),
      .fifo_count(fifo_count), .overflow(overflow),
      .overflow_clr(overflow_clr), .step_event(step_event)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Pop side of the scoreboard: compare each entry the consumer takes
   always @(negedge clk) begin
      arm_total += $countones(ch_arm);
      if (!rst && evt_valid && evt_ready) begin
         chk("sb_has_entry", 128'(sb.size() != 0), 128'(1));
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("evt_ch", 128'(evt_ch), 128'(e[98:96]));
            chk("evt_ts", 128'(evt_ts), 128'(e[95:0]));
         end
      end
   end

   task automatic reset_dut();
      rst = 1'b1;
      ch_locked = '0;
      ch_step = '0;
      evt_ready = 1'b0;
      overflow_clr = 1'b0;
      tick();
      rst = 1'b0;
      sb.delete();
      tick();
   endtask

   task automatic fire(input int ch, input logic [95:0] ts, input bit push);
      ch_ts[96*ch +: 96] = ts;
      ch_locked[ch] = 1'b1;
      if (push) sb.push_back({3'(ch), ts});
      tick();
      ch_locked[ch] = 1'b0;
      tick();
   endtask

   initial begin
      ch_ts = '0;
      cfg_enable = 4'hF;
      rst = 1'b1;
      ch_locked = '0;
      ch_step = '0;
      evt_ready = 1'b0;
      overflow_clr = 1'b0;
      tick(2);
      chk("rst_ch_enable", 128'(ch_enable), 128'(0));
      chk("rst_evt_valid", 128'(evt_valid), 128'(0));
      chk("rst_count", 128'(fifo_count), 128'(0));
      chk("rst_overflow", 128'(overflow), 128'(0));
      chk("rst_step_event", 128'(step_event), 128'(0));
      chk("rst_ch_arm", 128'(ch_arm), 128'(0));
      rst = 1'b0;
      tick();
      chk("ch_enable_copy", 128'(ch_enable), 128'(4'hF));

      // single event on channel 2, latency N+2
      ch_ts[96*2 +: 96] = 96'h1234;
      ch_locked[2] = 1'b1;
      tick();
      chk("lat_n1_valid", 128'(evt_valid), 128'(0));
      chk("lat_n1_arm", 128'(ch_arm), 128'(0));
      tick();
      chk("lat_n2_valid", 128'(evt_valid), 128'(1));
      chk("lat_n2_ch", 128'(evt_ch), 128'(2));
      chk("lat_n2_ts", 128'(evt_ts), 128'(96'h1234));
      chk("lat_n2_arm", 128'(ch_arm), 128'(4'b0100));
      chk("lat_n2_count", 128'(fifo_count), 128'(1));
      sb.push_back({3'd2, 96'h1234});
      evt_ready = 1'b1;
      tick();
      chk("arm_one_cycle", 128'(ch_arm), 128'(0));
      ch_locked[2] = 1'b0;
      tick(2);
      chk("t1_count", 128'(fifo_count), 128'(0));
      chk("t1_sb_empty", 128'(sb.size()), 128'(0));

      // all four channels together, round-robin from 0
      reset_dut();
      evt_ready = 1'b1;
      for (int i = 0; i < CH; i++) begin
         ch_ts[96*i +: 96] = 96'hA000 + 96'(i);
         sb.push_back({3'(i), 96'hA000 + 96'(i)});
      end
      ch_locked = 4'hF;
      tick(2);
      for (int i = 0; i < CH; i++) begin
         chk("rr_arm", 128'(ch_arm), 128'(4'b0001 << i));
         tick();
      end
      ch_locked = '0;
      tick(4);
      chk("rr_sb_empty", 128'(sb.size()), 128'(0));
      chk("rr_overflow", 128'(overflow), 128'(0));

      // nine events into a depth-8 queue with no consumer
      reset_dut();
      arm_base = arm_total;
      for (int i = 0; i < 9; i++) fire(i % CH, 96'(200 + i), i < 8);
      tick();
      chk("ovf_count", 128'(fifo_count), 128'(8));
      chk("ovf_flag", 128'(overflow), 128'(1));
      chk("ovf_arms", 128'(arm_total - arm_base), 128'(9));
      overflow_clr = 1'b1;
      tick();
      overflow_clr = 1'b0;
      chk("ovf_clear", 128'(overflow), 128'(0));
      evt_ready = 1'b1;
      tick(12);
      chk("ovf_sb_empty", 128'(sb.size()), 128'(0));
      chk("ovf_drained", 128'(fifo_count), 128'(0));

      // full queue, pop and grant in the same cycle
      reset_dut();
      for (int i = 0; i < 8; i++) fire(i % CH, 96'(300 + i), 1'b1);
      chk("full_count", 128'(fifo_count), 128'(8));
      ch_ts[96*3 +: 96] = 96'hBEEF;
      ch_locked[3] = 1'b1;
      sb.push_back({3'd3, 96'hBEEF});
      tick();
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      ch_locked[3] = 1'b0;
      chk("popwr_count", 128'(fifo_count), 128'(8));
      chk("popwr_overflow", 128'(overflow), 128'(0));
      evt_ready = 1'b1;
      tick(12);
      chk("popwr_sb_empty", 128'(sb.size()), 128'(0));

      // step edge with three entries queued
      reset_dut();
      for (int i = 0; i < 3; i++) fire(i, 96'(400 + i), 1'b1);
      chk("step_pre_count", 128'(fifo_count), 128'(3));
      ch_step[1] = 1'b1;
      tick();
      chk("step_pulse", 128'(step_event), 128'(1));
`ifdef PTP_EXTTS_SCHED_STEP_FLUSH_EN
      chk("step_count", 128'(fifo_count), 128'(0));
      sb.delete();
`else
      chk("step_count", 128'(fifo_count), 128'(3));
`endif
      ch_step = '0;
      tick();
      chk("step_pulse_end", 128'(step_event), 128'(0));
      evt_ready = 1'b1;
      tick(6);
      chk("step_sb_empty", 128'(sb.size()), 128'(0));

      // step and locked edge coincide: step wins
      ch_step[0] = 1'b1;
      ch_locked[0] = 1'b1;
      tick();
      chk("coinc_step", 128'(step_event), 128'(1));
      tick(2);
      chk("coinc_valid", 128'(evt_valid), 128'(0));
      chk("coinc_arm", 128'(ch_arm), 128'(0));
      ch_step = '0;
      ch_locked = '0;
      tick();

      // disabled channel ignores its edge
      cfg_enable = 4'b1110;
      tick();
      fire(0, 96'h55, 1'b0);
      tick();
      chk("dis_valid", 128'(evt_valid), 128'(0));
      cfg_enable = 4'hF;
      tick();

      // reset mid-operation with entries and pending grants
      reset_dut();
      for (int i = 0; i < 5; i++) fire(i % CH, 96'(500 + i), 1'b1);
      chk("midrst_pre", 128'(fifo_count), 128'(5));
      ch_locked[1] = 1'b1;
      ch_locked[3] = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      chk("midrst_count", 128'(fifo_count), 128'(0));
      chk("midrst_valid", 128'(evt_valid), 128'(0));
      chk("midrst_arm", 128'(ch_arm), 128'(0));
      rst = 1'b0;
      sb.delete();
      ch_locked = '0;
      tick();
      chk("postrst_arm", 128'(ch_arm), 128'(0));
      chk("postrst_valid", 128'(evt_valid), 128'(0));
      tick(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
